// File: rtl/synth_pkg.sv
// Shared MIDI constants, parser/UART state encodings and the command word layout.
package synth_pkg;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] CTRL       = 4'hB;
  localparam logic [6:0] CC_ALL_OFF = 7'd123;
  localparam logic [6:0] STOP_ALL   = 7'h7f;

  typedef enum logic [1:0] {IDLE, DATA1, DATA2, SKIP} parser_state_e;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} uart_state_e;

  // Command word seen by the downstream bank manager.
  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [7:0] vel;
  } midi_cmd_t;

  // Status nibbles that carry a two-byte message this parser acts on.
  function automatic logic is_voice(input logic [3:0] hi);
    return (hi == NOTE_OFF) || (hi == NOTE_ON) || (hi == CTRL);
  endfunction

endpackage

// File: rtl/midi_parser_p_if.sv
// Command output bundle of the MIDI parser.
interface midi_parser_p_if;
  logic [15:0] data;
  logic        valid;
  logic        frame_err;

  modport master (output data, output valid, output frame_err);
  modport slave  (input  data, input  valid, input  frame_err);
endinterface

// File: rtl/midi_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, frame-error lockout until idle.
module midi_uart_rx
  import synth_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 31250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int unsigned BIT_CLKS  = CLK_HZ / BAUD;
  localparam int unsigned HALF_CLKS = BIT_CLKS / 2;
  localparam int unsigned CNT_W     = $clog2(BIT_CLKS + 1);

  logic [1:0]       sync_q;
  logic             rx_s, rx_prev;
  uart_state_e      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_cnt, bit_d;
  logic [7:0]       shift_d;
  logic             byte_v_d, ferr_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= 2'b11;
      rx_prev      <= 1'b1;
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], i_rx};
      rx_prev      <= rx_s;
      state        <= state_d;
      cnt          <= cnt_d;
      bit_cnt      <= bit_d;
      o_byte       <= shift_d;
      o_byte_valid <= byte_v_d;
      o_frame_err  <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = CNT_W'(cnt + 1'b1);
    bit_d    = bit_cnt;
    shift_d  = o_byte;
    byte_v_d = 1'b0;
    ferr_d   = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_W'(HALF_CLKS - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_W'(BIT_CLKS - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, o_byte[7:1]};
          bit_d   = 3'(bit_cnt + 1'b1);
          if (bit_cnt == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_W'(BIT_CLKS - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_v_d = 1'b1;
            state_d  = RX_IDLE;
          end else begin
            ferr_d   = 1'b1;
            state_d  = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        cnt_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/midi_parser_p.sv
// MIDI byte parser: note on/off and All-Notes-Off to 16-bit commands, running status supported.
// Define MIDI_CHANNEL_FILTER_EN to accept only channel CHANNEL (default build is omni).
module midi_parser_p
  import synth_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned BAUD    = 31250,
  parameter int unsigned CHANNEL = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_rx,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_frame_err
);

`ifdef MIDI_CHANNEL_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif
  localparam logic [3:0] CHAN = 4'(CHANNEL);

  logic [7:0]    rx_byte;
  logic          rx_valid;
  parser_state_e state, state_d;
  logic [3:0]    rs, rs_d;
  logic [6:0]    d1, d1_d;
  midi_cmd_t     data_d;
  logic          valid_d;
  logic          chan_ok;

  midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_rx         (i_rx),
    .o_byte       (rx_byte),
    .o_byte_valid (rx_valid),
    .o_frame_err  (o_frame_err)
  );

  assign chan_ok = !FILTER_EN || (rx_byte[3:0] == CHAN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rs      <= '0;
      d1      <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_d;
      rs      <= rs_d;
      d1      <= d1_d;
      o_data  <= data_d;
      o_valid <= valid_d;
    end
  end

  // Running status is held as the status nibble; 0 means none.
  always_comb begin
    state_d = state;
    rs_d    = rs;
    d1_d    = d1;
    data_d  = '0;
    valid_d = 1'b0;
    if (rx_valid) begin
      if (rx_byte >= 8'hF8) begin
        state_d = state;
      end else if (rx_byte >= 8'hF0) begin
        rs_d    = '0;
        state_d = SKIP;
      end else if (rx_byte[7]) begin
        if (!chan_ok) begin
          rs_d    = '0;
          state_d = SKIP;
        end else begin
          rs_d    = rx_byte[7:4];
          state_d = is_voice(rx_byte[7:4]) ? DATA1 : SKIP;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (is_voice(rs)) begin
              d1_d    = rx_byte[6:0];
              state_d = DATA2;
            end
          end
          DATA1: begin
            d1_d    = rx_byte[6:0];
            state_d = DATA2;
          end
          DATA2: begin
            state_d = IDLE;
            unique case (rs)
              NOTE_ON, NOTE_OFF: begin
                if (d1 != 7'd0 && d1 != STOP_ALL) begin
                  valid_d     = 1'b1;
                  data_d.note = d1;
                  if (rs == NOTE_ON && rx_byte[6:0] != 7'd0) begin
                    data_d.on  = 1'b1;
                    data_d.vel = {1'b0, rx_byte[6:0]};
                  end
                end
              end
              CTRL: begin
                if (d1 == CC_ALL_OFF) begin
                  valid_d = 1'b1;
                  data_d  = '{on: 1'b0, note: STOP_ALL, vel: 8'h00};
                end
              end
              default: valid_d = 1'b0;
            endcase
          end
          default: state_d = SKIP;
        endcase
      end
    end
  end

endmodule

// File: doc/midi_parser_p.md
MIDI_PARSER_P -- requirements
Module: midi_parser_p

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, meaning MIDI serial bit rate.
REQ-003 SHALL have parameter CHANNEL, default 0, meaning MIDI channel (0-15) accepted when filtering is enabled.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_rx, input, 1, asynchronous MIDI serial line, idle high.
REQ-007 SHALL have port o_data, output, 16, command word: [15] 1=note-on, 0=note-off; [14:8] note; [7:0] {1'b0, velocity}.
REQ-008 SHALL have port o_valid, output, 1, one-cycle strobe qualifying o_data.
REQ-009 SHALL have port o_frame_err, output, 1, one-cycle strobe on a byte with a bad stop bit.

Function
REQ-010 SHALL drive o_data to 16'h0000 in every cycle in which o_valid is low, so that the downstream bank manager sees a harmless idle word.
REQ-011 SHALL pass i_rx through a 2-flop synchronizer before any use.
REQ-012 SHALL detect a start bit on a falling edge, re-check it low at half a bit period, then sample 8 data bits LSB-first and 1 stop bit, each at the bit centre, where one bit period is CLK_HZ/BAUD clocks.
REQ-013 SHALL discard a byte whose stop bit samples low, pulse o_frame_err for 1 cycle, and wait for i_rx high before re-arming.
REQ-014 SHALL run the parser FSM with states IDLE, DATA1, DATA2 and SKIP.
REQ-015 SHALL, on a received status byte 0x80-0xEF, store it as the running status and move to DATA1 for 0x8n/0x9n/0xBn, or to SKIP for all other status bytes.
REQ-016 SHALL ignore real-time bytes 0xF8-0xFF in any state, leaving both the state and the running status unchanged.
REQ-017 SHALL, on bytes 0xF0-0xF7, clear the running status and move to SKIP.
REQ-018 SHALL, on a data byte in IDLE with a valid 0x8n/0x9n/0xBn running status, latch the byte as data1 and move to DATA2, so that running status is supported.
REQ-019 SHALL, on a data byte in DATA1, latch data1 and move to DATA2.
REQ-020 SHALL, on a data byte in DATA2, emit the message and return to IDLE.
REQ-021 SHALL make SKIP discard data bytes; only a new status byte exits SKIP.
REQ-022 SHALL, when a status byte arrives in DATA1 or DATA2, abandon the partial message and process the new status byte.
REQ-023 SHALL emit note-on 0x9n with velocity>0 as {1,note,0,vel}.
REQ-024 SHALL emit 0x8n, and 0x9n with velocity 0, as {0,note,8'h00}.
REQ-025 SHALL drop note 0 and note 127 events without asserting o_valid, because 0 means "off" and 7'h7f means STOP_ALL downstream.
REQ-026 SHALL emit control change 0xBn with controller 123 (All Notes Off) as 16'h7F00; all other controllers SHALL be dropped.
REQ-027 SHALL assert o_valid exactly 1 cycle after the UART byte-complete strobe of the final data byte.
REQ-028 SHALL emit at most one command per message.

Reset
REQ-029 SHALL, while reset_n is low, set o_data=0, o_valid=0, o_frame_err=0, FSM=IDLE, running status=none, UART idle, synchronizer=1, regardless of any byte in flight.
REQ-030 SHALL discard any byte partially received when reset deasserts; reception restarts at the next falling edge.

Configuration
REQ-031 SHALL, with MIDI_CHANNEL_FILTER_EN defined, accept channel messages only when status[3:0]==CHANNEL; on other channels it SHALL set SKIP and clear the running status.
REQ-032 SHALL, without MIDI_CHANNEL_FILTER_EN defined, accept messages on all 16 channels (omni).

Structure
REQ-033 SHALL place the status constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, CTRL=4'hB, CC_ALL_OFF=123, STOP_ALL=7'h7f) and the FSM state enumeration in shared package synth_pkg.
REQ-034 SHALL implement the UART receiver as sub-module midi_uart_rx (ports clk, reset_n, i_rx, o_byte[7:0], o_byte_valid, o_frame_err); the parser FSM SHALL reside in midi_parser_p.

Verification
REQ-035 SHALL verify that serial 0x90,0x3C,0x64 yields one o_valid with o_data=16'hBC64.
REQ-036 SHALL verify that 0x90,0x3C,0x64,0x40,0x00 (running status) yields 16'hBC64 followed by 16'h4000.
REQ-037 SHALL verify that 0x90,0xF8,0x3C,0xFE,0x50 yields a single 16'hBC50, with the real-time bytes ignored.
REQ-038 SHALL verify that 0xB0,0x7B,0x00 yields 16'h7F00, and that 0x90,0x00,0x40 and 0x80,0x7F,0x00 yield no o_valid.
REQ-039 SHALL verify that a byte with stop bit forced low yields one o_frame_err pulse and no o_valid, and that a following 0x80,0x3C,0x00 yields 16'h3C00.
REQ-040 SHALL verify that, with MIDI_CHANNEL_FILTER_EN and CHANNEL=0, 0x91,0x3C,0x64 yields no output; and that reset_n pulsed low mid-byte leaves o_data=0 and the next full message parses correctly.
